// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment display path: active-low glyphs,
// blank/off patterns and the digit-index type.
package seg7_pkg;

    // Segment order is {g,f,e,d,c,b,a}, active-low. Entry n is the glyph for hex n.
    localparam logic [15:0][6:0] SEG_GLYPHS = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [7:0] AN_OFF    = 8'hFF;

    typedef logic [2:0] digit_idx_t;

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low 7-segment glyph decoder.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG_GLYPHS[nibble_i];

endmodule

// File: rtl/gpio_seg7_display.sv
// Captures the 32-bit GPIO result word and scans it as 8 hex digits on a
// multiplexed common-anode 7-segment display. Each digit stays lit for
// REFRESH_DIV clocks; all outputs are registered.
// Optional build macro SEG7_BLANK_LEADING_ZEROS_EN: digits above the highest
// nonzero nibble are blanked (digit 0 always shows).
module gpio_seg7_display
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int DIGITS      = 8
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       datos_in,
    input  logic              valid_in,
    output logic [DIGITS-1:0] an,
    output logic [6:0]        seg,
    output logic              dp,
    output logic              captured
);

    localparam int             PW         = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0]  PRESC_TERM = PW'(REFRESH_DIV - 1);

    logic [31:0]       value_q, value_d;
    logic              captured_q, captured_d;
    logic [PW-1:0]     presc_q, presc_d;
    digit_idx_t        idx_q, idx_d;
    logic [DIGITS-1:0] an_q, an_d;
    logic [6:0]        seg_q, seg_d;

    logic              tick;
    logic [3:0]        nibble;
    logic [6:0]        glyph;
    logic              lead_blank;

    // Nibble shown by the digit currently being scanned.
    assign nibble = value_q[{idx_q, 2'b00} +: 4];

    hex_to_seg7 u_dec (
        .nibble_i (nibble),
        .seg_o    (glyph)
    );

`ifdef SEG7_BLANK_LEADING_ZEROS_EN
    // A digit is a leading zero when it and every more significant nibble is 0.
    logic [31:0] upper;
    assign upper      = value_q >> {idx_q, 2'b00};
    assign lead_blank = (idx_q != '0) && (upper == '0);
`else
    assign lead_blank = 1'b0;
`endif

    // Capture, prescaler, scan index and next output pattern.
    always_comb begin
        tick       = (presc_q == PRESC_TERM);
        presc_d    = tick ? '0 : presc_q + PW'(1);
        idx_d      = tick ? idx_q + 3'd1 : idx_q;
        value_d    = valid_in ? datos_in : value_q;
        captured_d = captured_q | valid_in;
        an_d       = ~(DIGITS'(1) << idx_q);
        seg_d      = lead_blank ? SEG_BLANK : glyph;
    end

    // State and output registers; reset blanks the display and clears the capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            value_q    <= '0;
            captured_q <= 1'b0;
            presc_q    <= '0;
            idx_q      <= '0;
            an_q       <= DIGITS'(AN_OFF);
            seg_q      <= SEG_BLANK;
        end else begin
            value_q    <= value_d;
            captured_q <= captured_d;
            presc_q    <= presc_d;
            idx_q      <= idx_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
        end
    end

    assign an       = an_q;
    assign seg      = seg_q;
    assign dp       = 1'b1;
    assign captured = captured_q;

endmodule

// File: tb/tb_gpio_seg7_display.sv
// Directed bench for gpio_seg7_display with REFRESH_DIV=4.
// cyc counts posedges since the last reset release; the digit lit after
// edge cyc is ((cyc-1)/4) % 8.
module tb_gpio_seg7_display;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_in = 1'b0;
    logic [31:0] datos_in = '0;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        captured;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    gpio_seg7_display #(.REFRESH_DIV(4), .DIGITS(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .datos_in (datos_in),
        .valid_in (valid_in),
        .an       (an),
        .seg      (seg),
        .dp       (dp),
        .captured (captured)
    );

    localparam logic [0:7][7:0] AN_OF = {8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    // Glyphs of 32'h1234ABCD, digit 0 first: D C b A 4 3 2 1
    localparam logic [0:7][6:0] SCAN_SEG = {7'h21, 7'h46, 7'h03, 7'h08, 7'h19, 7'h30, 7'h24, 7'h79};
    localparam logic [6:0] G0 = 7'h40;
    localparam logic [6:0] GA = 7'h08;
    localparam logic [6:0] G9 = 7'h10;
`ifdef SEG7_BLANK_LEADING_ZEROS_EN
    localparam logic [6:0] LZ = 7'h7F;   // leading zero digit is blank
`else
    localparam logic [6:0] LZ = 7'h40;   // leading zero digit shows "0"
`endif

    typedef struct {
        logic        valid;
        logic [31:0] data;
        logic [7:0]  an;
        logic [6:0]  seg;
        logic        cap;
    } vec_t;

    vec_t tbl [32];

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string nm, input logic [7:0] ea, input logic [6:0] es, input logic ec);
        total++;
        if (an !== ea || seg !== es || dp !== 1'b1 || captured !== ec) begin
            bad++;
            $display("FAIL %s cyc=%0d: got an=%h seg=%h dp=%b cap=%b, want an=%h seg=%h dp=1 cap=%b",
                     nm, cyc, an, seg, dp, captured, ea, es, ec);
        end
    endtask

    function automatic int dig(input int m);
        return ((m - 1) / 4) % 8;
    endfunction

    initial begin
        // Scan table for 32 cycles starting at cyc=4 with 32'h1234ABCD loaded.
        for (int i = 0; i < 32; i++) begin
            tbl[i].valid = 1'b0;
            tbl[i].data  = 32'h0;
            tbl[i].an    = AN_OF[((i + 3) / 4) % 8];
            tbl[i].seg   = SCAN_SEG[((i + 3) / 4) % 8];
            tbl[i].cap   = 1'b1;
        end

        // Reset held 3 cycles
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("reset", 8'hFF, 7'h7F, 1'b0);
        end

        // First lit output is digit 0 showing "0"
        rst = 1'b0;
        cyc = 0;
        step();
        chk("release", 8'hFE, G0, 1'b0);

        // Capture latency
        valid_in = 1'b1;
        datos_in = 32'h1234ABCD;
        step();
        valid_in = 1'b0;
        datos_in = 32'h0;
        chk("cap_flag", 8'hFE, G0, 1'b1);
        step();
        chk("cap_seg", 8'hFE, 7'h21, 1'b1);

        // Free-running scan order
        for (int i = 0; i < 32; i++) begin
            valid_in = tbl[i].valid;
            datos_in = tbl[i].data;
            step();
            chk("scan", tbl[i].an, tbl[i].seg, tbl[i].cap);
        end

        // Capture on the tick edge (prescaler at terminal count before cyc 36)
        valid_in = 1'b1;
        datos_in = 32'h5;
        step();
        chk("tick_cap", 8'hFE, 7'h21, 1'b1);
        datos_in = 32'h7;
        step();
        chk("hold", 8'hFD, LZ, 1'b1);
        datos_in = 32'h9;
        step();
        chk("hold", 8'hFD, LZ, 1'b1);
        valid_in = 1'b0;
        datos_in = 32'h0;

        // No skipped digit; last write (9) shows when digit 0 comes round; stop at digit 5
        while (cyc < 86) begin
            step();
            chk("after_hold", AN_OF[dig(cyc)], (dig(cyc) == 0) ? G9 : LZ, 1'b1);
        end

        // Reset mid-scan with a competing capture
        rst = 1'b1;
        valid_in = 1'b1;
        datos_in = 32'hFFFFFFFF;
        step();
        chk("rst_mid", 8'hFF, 7'h7F, 1'b0);
        step();
        chk("rst_mid", 8'hFF, 7'h7F, 1'b0);
        valid_in = 1'b0;
        datos_in = 32'h0;
        rst = 1'b0;
        cyc = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("restart", AN_OF[dig(cyc)], (dig(cyc) == 0) ? G0 : LZ, 1'b0);
        end

        // Capture 32'h000000A0
        valid_in = 1'b1;
        datos_in = 32'h000000A0;
        step();
        valid_in = 1'b0;
        datos_in = 32'h0;
        chk("lz_a0_cap", 8'hFD, LZ, 1'b1);
        for (int i = 0; i < 32; i++) begin
            step();
            chk("lz_a0", AN_OF[dig(cyc)],
                (dig(cyc) == 0) ? G0 : (dig(cyc) == 1) ? GA : LZ, 1'b1);
        end

        // Capture zero
        valid_in = 1'b1;
        datos_in = 32'h0;
        step();
        valid_in = 1'b0;
        chk("lz_zero_cap", 8'hFD, GA, 1'b1);
        for (int i = 0; i < 32; i++) begin
            step();
            chk("lz_zero", AN_OF[dig(cyc)], (dig(cyc) == 0) ? G0 : LZ, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
